// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction fetch stage
package fetch_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] INSTR_BYTES = 32'd4;
  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
  typedef enum logic [2:0] {BOOT, FETCH, HOLD, DRAIN, HALT} state_t;
endpackage

// File: rtl/fetch_prefetch_slot.sv
// fetch_prefetch_slot: one-entry prefetch buffer, clear beats load beats take
module fetch_prefetch_slot
  import fetch_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            i_load,
  input  logic            i_clear,
  input  logic            i_take,
  input  logic [XLEN-1:0] i_data,
  input  logic [XLEN-1:0] i_pc,
  output logic            o_valid,
  output logic [XLEN-1:0] o_data,
  output logic [XLEN-1:0] o_pc
);
  logic            r_valid;
  logic [XLEN-1:0] r_data;
  logic [XLEN-1:0] r_pc;
  always_ff @(posedge clk) begin
    r_valid <= (rst || i_clear) ? 1'b0 : i_load ? 1'b1 : i_take ? 1'b0 : r_valid;
    if (i_load && !i_clear) begin
      r_data <= i_data;
      r_pc   <= i_pc;
    end
  end
  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_pc    = r_pc;
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC holder and imem req/ack fetcher with one-entry prefetch and jump redirect
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
)(
  input  logic            clk,
  input  logic            rst,
  input  logic            i_jump_valid,
  input  logic [XLEN-1:0] i_jump_target,
  input  logic            i_stall,
  output logic            o_imem_req,
  output logic [XLEN-1:0] o_imem_addr,
  input  logic            i_imem_ack,
  input  logic [XLEN-1:0] i_imem_data,
  output logic [XLEN-1:0] o_instruction,
  output logic [XLEN-1:0] o_fetch_pc,
  output logic            o_inst_valid,
  output logic            o_misaligned
);
  state_t          r_state;
  logic            r_req;
  logic            r_valid;
  logic            r_mis;
  logic [XLEN-1:0] r_addr;
  logic [XLEN-1:0] r_instr;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_tgt;
  logic            w_ack;
  logic            w_pend;
  logic            w_cons;
  logic            w_bad;
  logic            w_slot_v;
  logic [XLEN-1:0] w_slot_data;
  logic [XLEN-1:0] w_slot_pc;
  logic            w_load;
  logic            w_clear;
  logic            w_take;
  always_comb begin
    w_ack   = r_req && i_imem_ack;
    w_pend  = r_req && !i_imem_ack;
    w_cons  = (r_state == HOLD) && r_valid && !i_stall;
    w_bad   = i_jump_target[1:0] != 2'b00;
    w_load  = (r_state == HOLD) && w_ack && !w_cons;
    w_clear = w_cons && i_jump_valid;
    w_take  = w_cons && !i_jump_valid && w_slot_v;
  end
  fetch_prefetch_slot u_slot (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_load),
    .i_clear (w_clear),
    .i_take  (w_take),
    .i_data  (i_imem_data),
    .i_pc    (r_addr),
    .o_valid (w_slot_v),
    .o_data  (w_slot_data),
    .o_pc    (w_slot_pc)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= BOOT;
      r_req   <= 1'b0;
      r_valid <= 1'b0;
      r_mis   <= 1'b0;
      r_addr  <= RESET_PC;
      r_instr <= '0;
      r_pc    <= RESET_PC;
      r_tgt   <= RESET_PC;
    end else begin
      case (r_state)
        BOOT: begin
          r_state <= FETCH;
          r_req   <= 1'b1;
          r_addr  <= RESET_PC;
        end
        FETCH: if (w_ack) begin
          r_state <= HOLD;
          r_instr <= i_imem_data;
          r_pc    <= r_addr;
          r_valid <= 1'b1;
          r_addr  <= r_addr + INSTR_BYTES;
        end
        HOLD: if (!w_cons) begin
          if (w_ack) r_req <= 1'b0;
        end else if (i_jump_valid) begin
          r_valid <= 1'b0;
          r_tgt   <= i_jump_target;
          if (w_bad) r_mis <= 1'b1;
          if (w_pend) r_state <= DRAIN;
          else begin
            r_state <= w_bad ? HALT : FETCH;
            r_req   <= !w_bad;
            if (!w_bad) r_addr <= i_jump_target;
          end
        end else if (w_slot_v) begin
          r_instr <= w_slot_data;
          r_pc    <= w_slot_pc;
          r_req   <= 1'b1;
          r_addr  <= w_slot_pc + INSTR_BYTES;
        end else if (w_ack) begin
          r_instr <= i_imem_data;
          r_pc    <= r_addr;
          r_addr  <= r_addr + INSTR_BYTES;
        end else begin
          r_state <= FETCH;
          r_valid <= 1'b0;
          r_req   <= 1'b1;
          r_addr  <= r_pc + INSTR_BYTES;
        end
        DRAIN: if (w_ack) begin
          r_state <= r_mis ? HALT : FETCH;
          r_req   <= !r_mis;
          if (!r_mis) r_addr <= r_tgt;
        end
        default: r_req <= 1'b0;
      endcase
    end
  end
  assign o_imem_req    = r_req;
  assign o_imem_addr   = r_addr;
  assign o_instruction = r_instr;
  assign o_fetch_pc    = r_pc;
  assign o_inst_valid  = r_valid;
  assign o_misaligned  = r_mis;
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed vector and sequence checks of fetch_unit against a latency-configurable memory
module tb_fetch_unit;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        jv = 1'b0;
  logic [31:0] jt = '0;
  logic        stall = 1'b0;
  logic        req;
  logic [31:0] addr;
  logic        ack;
  logic [31:0] data;
  logic [31:0] instr;
  logic [31:0] pc;
  logic        valid;
  logic        mis;
  int          lat = 0;
  int          cnt = 0;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] q[$];
  logic        p_rst, p_req, p_ack;
  logic [31:0] p_addr;
  typedef struct {
    logic        stall;
    logic        jv;
    logic [31:0] jt;
    logic        req;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] pc;
    logic        mis;
  } vec_t;
  vec_t vec[12];
  fetch_unit dut (
    .clk           (clk),
    .rst           (rst),
    .i_jump_valid  (jv),
    .i_jump_target (jt),
    .i_stall       (stall),
    .o_imem_req    (req),
    .o_imem_addr   (addr),
    .i_imem_ack    (ack),
    .i_imem_data   (data),
    .o_instruction (instr),
    .o_fetch_pc    (pc),
    .o_inst_valid  (valid),
    .o_misaligned  (mis)
  );
  always #5 clk = ~clk;
  assign ack  = req && (cnt >= lat);
  assign data = ~addr;
  always @(posedge clk) cnt <= (rst || !req || ack) ? 0 : cnt + 1;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (!rst && valid && !stall) begin
      chk("instr_data", instr, ~pc);
      q.push_back(pc);
    end
    if (!p_rst && p_req && !p_ack) begin
      chk("req_hold", {31'd0, req}, 32'd1);
      chk("addr_hold", addr, p_addr);
    end
    p_rst  <= rst;
    p_req  <= req;
    p_ack  <= ack;
    p_addr <= addr;
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    rst = 1'b1;
    stall = 1'b0;
    jv = 1'b0;
    jt = '0;
    step();
    rst = 1'b0;
  endtask
  task automatic wait_pc(input logic [31:0] want, input string name);
    logic found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      step();
      found = valid && (pc == want);
    end
    chk(name, {31'd0, found}, 32'd1);
  endtask
  initial begin
    logic [31:0] exp_q[4];
    vec[0]  = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h0,   1'b0, 32'h0,   1'b0};
    vec[1]  = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h4,   1'b1, 32'h0,   1'b0};
    vec[2]  = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h8,   1'b1, 32'h4,   1'b0};
    vec[3]  = '{1'b0, 1'b0, 32'h0,   1'b1, 32'hC,   1'b1, 32'h8,   1'b0};
    vec[4]  = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h10,  1'b1, 32'hC,   1'b0};
    vec[5]  = '{1'b0, 1'b1, 32'h100, 1'b1, 32'h100, 1'b0, 32'h0,   1'b0};
    vec[6]  = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h104, 1'b1, 32'h100, 1'b0};
    vec[7]  = '{1'b1, 1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 32'h100, 1'b0};
    vec[8]  = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h108, 1'b1, 32'h104, 1'b0};
    vec[9]  = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h10C, 1'b1, 32'h108, 1'b0};
    vec[10] = '{1'b0, 1'b1, 32'h103, 1'b0, 32'h0,   1'b0, 32'h0,   1'b1};
    vec[11] = '{1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h0,   1'b1};
    step();
    chk("rst_req", {31'd0, req}, 32'd0);
    chk("rst_valid", {31'd0, valid}, 32'd0);
    chk("rst_instr", instr, 32'd0);
    chk("rst_pc", pc, 32'd0);
    chk("rst_mis", {31'd0, mis}, 32'd0);
    rst = 1'b0;
    for (int k = 0; k < 12; k++) begin
      stall = vec[k].stall;
      jv    = vec[k].jv;
      jt    = vec[k].jt;
      step();
      chk($sformatf("vec%0d_req", k), {31'd0, req}, {31'd0, vec[k].req});
      if (vec[k].req) chk($sformatf("vec%0d_addr", k), addr, vec[k].addr);
      chk($sformatf("vec%0d_valid", k), {31'd0, valid}, {31'd0, vec[k].valid});
      if (vec[k].valid) begin
        chk($sformatf("vec%0d_pc", k), pc, vec[k].pc);
        chk($sformatf("vec%0d_instr", k), instr, ~vec[k].pc);
      end
      chk($sformatf("vec%0d_mis", k), {31'd0, mis}, {31'd0, vec[k].mis});
    end
    lat = 3;
    do_reset();
    q.delete();
    wait_pc(32'h4, "b_reach_pc4");
    jv = 1'b1;
    jt = 32'h100;
    step();
    jv = 1'b0;
    chk("b_drain_valid", {31'd0, valid}, 32'd0);
    chk("b_drain_req", {31'd0, req}, 32'd1);
    chk("b_drain_addr", addr, 32'h8);
    for (int i = 0; i < 10 && addr == 32'h8; i++) step();
    chk("b_redirect_addr", addr, 32'h100);
    chk("b_redirect_req", {31'd0, req}, 32'd1);
    for (int i = 0; i < 100 && q.size() < 4; i++) step();
    chk("b_count", q.size(), 32'd4);
    exp_q = '{32'h0, 32'h4, 32'h100, 32'h104};
    for (int i = 0; i < 4 && i < q.size(); i++) chk($sformatf("b_order%0d", i), q[i], exp_q[i]);
    lat = 0;
    do_reset();
    wait_pc(32'h0, "c_reach_pc0");
    jv = 1'b1;
    jt = 32'hFFFF_FFFC;
    step();
    jv = 1'b0;
    chk("c_jump_addr", addr, 32'hFFFF_FFFC);
    step();
    chk("c_top_pc", pc, 32'hFFFF_FFFC);
    chk("c_top_valid", {31'd0, valid}, 32'd1);
    chk("c_wrap_addr", addr, 32'h0);
    stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk($sformatf("c_stall%0d_pc", i), pc, 32'hFFFF_FFFC);
      chk($sformatf("c_stall%0d_valid", i), {31'd0, valid}, 32'd1);
      chk($sformatf("c_stall%0d_instr", i), instr, 32'h0000_0003);
    end
    stall = 1'b0;
    step();
    chk("c_wrap_pc", pc, 32'h0);
    chk("c_wrap_valid", {31'd0, valid}, 32'd1);
    step();
    chk("c_next_pc", pc, 32'h4);
    lat = 3;
    do_reset();
    wait_pc(32'h4, "d_reach_pc4");
    jv = 1'b1;
    jt = 32'h102;
    step();
    jv = 1'b0;
    chk("d_mis_set", {31'd0, mis}, 32'd1);
    chk("d_mis_valid", {31'd0, valid}, 32'd0);
    chk("d_mis_drain_req", {31'd0, req}, 32'd1);
    for (int i = 0; i < 10 && req; i++) step();
    chk("d_halt_req", {31'd0, req}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("d_halt%0d_mis", i), {31'd0, mis}, 32'd1);
      chk($sformatf("d_halt%0d_req", i), {31'd0, req}, 32'd0);
      chk($sformatf("d_halt%0d_valid", i), {31'd0, valid}, 32'd0);
    end
    rst = 1'b1;
    step();
    chk("d_rst_mis", {31'd0, mis}, 32'd0);
    chk("d_rst_pc", pc, 32'd0);
    chk("d_rst_valid", {31'd0, valid}, 32'd0);
    rst = 1'b0;
    step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage of the RISC-V core. Sits directly upstream of the decode/control-flow block.
- Holds the program counter and fetches 32-bit words from instruction memory over a req/ack handshake.
- Presents one instruction plus its PC to decode, with a one-entry prefetch of PC+4.
- Consumes the control block's jump decision (Should_Jump / PC_Out): redirects the PC, discards wrong-path prefetch, and traps on misaligned targets.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
Jump_Valid  input  1  taken branch/jump for the instruction currently presented (Should_Jump)
Jump_Target  input  32  redirect target (PC_Out); sampled only with Jump_Valid
Stall  input  1  decode not consuming the presented instruction this cycle
Imem_Req  output  1  instruction-memory request
Imem_Addr  output  32  word address of request; bits [1:0] always 0
Imem_Ack  input  1  request complete; Imem_Data valid this cycle; may arrive in the same cycle as Imem_Req
Imem_Data  input  32  fetched word
Instruction  output  32  presented instruction
Fetch_PC  output  32  PC of presented instruction
Inst_Valid  output  1  Instruction/Fetch_PC valid
Misaligned  output  1  sticky trap: taken target with bits [1:0] != 0

Behaviour:
- Reset (rst=1 at an edge):
  - Outputs: Imem_Req=0, Inst_Valid=0, Instruction=0, Fetch_PC=RESET_PC, Misaligned=0.
  - Internal: prefetch slot empty, state=BOOT.
  - rst mid-operation abandons any outstanding request; memory must tolerate this.
- Handshake rules:
  - Once Imem_Req=1, Imem_Req and Imem_Addr hold stable until the Imem_Ack cycle.
  - At most one request outstanding.
  - Imem_Req may drop, or change address, only in the cycle after an ack.
- Consume event: Inst_Valid=1 and Stall=0.
  - Jump_Valid/Jump_Target are ignored outside consume events.
- States:
  - BOOT: one cycle, then FETCH with Imem_Addr=RESET_PC.
  - FETCH: request the demand address (next_pc).
    - On ack: Instruction<=Imem_Data, Fetch_PC<=next_pc, Inst_Valid<=1 next cycle; go to HOLD.
    - Demand-fetch latency is 1 cycle after ack.
  - HOLD: instruction presented. Prefetch of Fetch_PC+4 is issued the same cycle HOLD is entered; its data goes into the prefetch slot on ack.
    - Consume, no jump, slot full: next cycle Instruction<=slot, Fetch_PC+=4, Inst_Valid stays 1, slot cleared, new prefetch issued. Back-to-back, 1 instr/cycle.
    - Consume, no jump, prefetch acked in the same cycle: Instruction<=Imem_Data directly; same result.
    - Consume, no jump, prefetch still outstanding: Inst_Valid<=0; go to FETCH, keeping the same request (no re-issue).
    - Consume with jump, Jump_Target[1:0]==0: clear slot, Inst_Valid<=0, next_pc<=Jump_Target. Go to FETCH if no request remains outstanding (including ack in this same cycle). Otherwise go to DRAIN.
    - Consume with jump, Jump_Target[1:0]!=0: Misaligned<=1, Inst_Valid<=0, slot cleared. Go to DRAIN if a request is outstanding, else HALT.
  - DRAIN: hold the wrong-path request until ack; drop its data. Then go to FETCH (target) or HALT (misaligned).
  - HALT: Imem_Req=0, Inst_Valid=0, Misaligned=1 until rst.
- Arithmetic: PC+4 is modulo 2^32; 32'hFFFF_FFFC wraps to 0.
- Stall=1 freezes Instruction/Fetch_PC/Inst_Valid. A prefetch still completes into the slot while stalled.

Decomposition:
- Shared package fetch_pkg:
  - state enum {BOOT, FETCH, HOLD, DRAIN, HALT}
  - INSTR_BYTES=4
  - XLEN=32
  - default RESET_PC
- One sub-module: fetch_prefetch_slot. It is a one-entry buffer (data, pc, valid) with load/clear/take, where clear has priority over load.

Test Plan:
- Reset, RESET_PC=0, combinational memory (Ack same cycle as Req), Stall=0, no jumps -> Fetch_PC sequence 0,4,8,C with Inst_Valid=1 every cycle from the first valid onward.
- Memory ack latency 3 cycles -> Imem_Addr held stable through the wait. Each instruction is presented exactly once, in order, with no duplicates.
- Jump_Valid=1, Jump_Target=32'h100 on consume while prefetch of 0x8 is outstanding -> DRAIN. The 0x8 data is never presented; next Imem_Addr=0x100; next Fetch_PC=0x100.
- Same jump with prefetch acked in the consume cycle -> no DRAIN; Imem_Addr=0x100 the next cycle.
- Jump_Target=32'h102 -> Misaligned=1 next cycle and stays set. Imem_Req=0 after drain, Inst_Valid=0. Only rst clears it; after reset Fetch_PC=RESET_PC.
- Stall=1 for 5 cycles at Fetch_PC=0xFFFF_FFFC -> outputs frozen. On release the next Fetch_PC=0x0 (wrap).
